// File: rtl/uart_pkg.sv
// Constants and types shared by the OrangeCrab UART transmitter and receiver.
// Bit timing is derived from the 48 MHz reference clock and the 19200 baud rate.
package uart_pkg;

  localparam int CLK_HZ       = 48_000_000;
  localparam int BAUD         = 19_200;
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  // 2-of-3 vote used to reject a single-cycle glitch at the bit centre.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side UART bundle: serial line in, byte holding register and status out.
// The slave modport is the receiver; the master modport is the byte consumer.
interface uart_rx_if;

  logic       rx_in;
  logic       rx_r_n;
  logic [7:0] rx_data;
  logic       rx_ready_n;
  logic       rx_busy_n;
  logic       rx_ferr_n;
  logic       rx_overrun_n;

  modport slave (
    input  rx_in,
    input  rx_r_n,
    output rx_data,
    output rx_ready_n,
    output rx_busy_n,
    output rx_ferr_n,
    output rx_overrun_n
  );

  modport master (
    output rx_in,
    output rx_r_n,
    input  rx_data,
    input  rx_ready_n,
    input  rx_busy_n,
    input  rx_ferr_n,
    input  rx_overrun_n
  );

endinterface

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for an asynchronous input pin.
// RST_VAL matches the pin's idle level so reset never looks like an edge.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with majority-voted bit sampling and a one-byte holding
// register read through an active-low ready/read strobe pair.
module uart_rx #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT
) (
  input logic      clk_48,
  input logic      rst_n,
  uart_rx_if.slave bus
);

  import uart_pkg::*;

  // CLKS_PER_BIT must be at least 8 so the three samples fit before the wrap.
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int HALF  = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_EARLY  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_MID    = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(HALF + 1);

  logic s;
  logic s_prev_q;

  rx_state_t        state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [2:0]       idx_q,       idx_d;
  logic             early_q,     early_d;
  logic             mid_q,       mid_d;
  logic [7:0]       shift_q,     shift_d;
  logic [7:0]       data_q,      data_d;
  logic             ready_n_q,   ready_n_d;
  logic             busy_n_q,    busy_n_d;
  logic             ferr_n_q,    ferr_n_d;
  logic             overrun_n_q, overrun_n_d;

  logic             cnt_wrap;
  logic [CNT_W-1:0] cnt_inc;
  logic             bit_val;

  sync2 #(
    .RST_VAL (1'b1)
  ) u_sync_rx (
    .clk   (clk_48),
    .rst_n (rst_n),
    .d_i   (bus.rx_in),
    .q_o   (s)
  );

  assign cnt_wrap = (cnt_q == CNT_LAST);
  assign cnt_inc  = cnt_wrap ? '0 : cnt_q + CNT_ONE;
  assign bit_val  = majority3(early_q, mid_q, s);

  // NOTE: every next-state signal is defaulted to its current value first, so
  // no path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    early_d     = early_q;
    mid_d       = mid_q;
    shift_d     = shift_q;
    data_d      = data_q;
    ready_n_d   = ready_n_q;
    busy_n_d    = busy_n_q;
    ferr_n_d    = 1'b1;
    overrun_n_d = overrun_n_q;

    if (!bus.rx_r_n && !ready_n_q) begin
      ready_n_d   = 1'b1;
      overrun_n_d = 1'b1;
    end

    if (cnt_q == CNT_EARLY) early_d = s;
    if (cnt_q == CNT_MID)   mid_d   = s;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // The detection cycle itself counts as cnt 0 of the start bit.
        if (s_prev_q && !s) begin
          cnt_d    = CNT_ONE;
          idx_d    = 3'd0;
          busy_n_d = 1'b0;
          state_d  = START;
        end
      end

      START: begin
        cnt_d = cnt_inc;
        if (cnt_q == CNT_DECIDE && bit_val) begin
          cnt_d    = '0;
          busy_n_d = 1'b1;
          state_d  = IDLE;
        end else if (cnt_wrap) begin
          state_d = DATA;
        end
      end

      DATA: begin
        cnt_d = cnt_inc;
        if (cnt_q == CNT_DECIDE) shift_d = {bit_val, shift_q[7:1]};
        if (cnt_wrap) begin
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end

      STOP: begin
        cnt_d = cnt_inc;
        // Leave at the stop-bit centre so a back-to-back start edge is not missed.
        if (cnt_q == CNT_DECIDE) begin
          cnt_d    = '0;
          busy_n_d = 1'b1;
          if (bit_val) begin
            state_d = IDLE;
            if (ready_n_q || !bus.rx_r_n) begin
              data_d    = shift_q;
              ready_n_d = 1'b0;
            end else begin
              overrun_n_d = 1'b0;
            end
          end else begin
            ferr_n_d = 1'b0;
            state_d  = WAIT_IDLE;
          end
        end
      end

      WAIT_IDLE: begin
        cnt_d = '0;
        if (s) state_d = IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_48) begin
    if (!rst_n) begin
      s_prev_q    <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      early_q     <= 1'b1;
      mid_q       <= 1'b1;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      ready_n_q   <= 1'b1;
      busy_n_q    <= 1'b1;
      ferr_n_q    <= 1'b1;
      overrun_n_q <= 1'b1;
    end else begin
      s_prev_q    <= s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      early_q     <= early_d;
      mid_q       <= mid_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      ready_n_q   <= ready_n_d;
      busy_n_q    <= busy_n_d;
      ferr_n_q    <= ferr_n_d;
      overrun_n_q <= overrun_n_d;
    end
  end

  assign bus.rx_data      = data_q;
  assign bus.rx_ready_n   = ready_n_q;
  assign bus.rx_busy_n    = busy_n_q;
  assign bus.rx_ferr_n    = ferr_n_q;
  assign bus.rx_overrun_n = overrun_n_q;

endmodule
